// File: rtl/empty_cell_scanner.sv
// -----------------------------------------------------------------------------
// empty_cell_scanner
//
// Sequential search for the first empty board cell. A cell is empty when its
// code is all-zeros or all-ones. On an accepted `start` the whole cell array
// is snapshotted and walked one cell per clock beginning at `start_idx`. The
// first empty cell ends the scan with found=1 and its index/code. If no empty
// cell is met before the last candidate, the scan ends with found=0.
//
// Build option:
//   EMPTY_SCAN_WRAP_EN  defined     -> pointer wraps NCELLS-1 -> 0 and up to
//                                      NCELLS cells are examined.
//                       not defined -> scan stops after cell NCELLS-1.
//
// Parameters:
//   NCELLS  number of board cells (>= 2)
//   CELL_W  bits per cell code (>= 2)
//   IDX_W   index width, derived from NCELLS (do not override)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cells      flattened cell codes, cell i = cells[i*CELL_W +: CELL_W]
//   start      scan request, accepted only while busy=0
//   start_idx  first cell to examine, sampled with start
//   busy       scan in progress
//   done       one-cycle pulse, result valid
//   found      an empty cell was found
//   idx        index of the found cell (0 if none)
//   state      code of the found cell (0 if none)
// -----------------------------------------------------------------------------
module empty_cell_scanner #(
    parameter int NCELLS = 16,
    parameter int CELL_W = 4,
    parameter int IDX_W  = $clog2(NCELLS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCELLS*CELL_W-1:0] cells,
    input  logic                     start,
    input  logic [IDX_W-1:0]         start_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [IDX_W-1:0]         idx,
    output logic [CELL_W-1:0]        state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCELLS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W:0]   NCELLS_EXT = (IDX_W + 1)'(NCELLS);

    // A cell is empty when its code is uniformly 0 or uniformly 1.
    function automatic logic is_empty(input logic [CELL_W-1:0] code);
        return (code == {CELL_W{1'b0}}) || (code == {CELL_W{1'b1}});
    endfunction

    logic [1:0]        fsm_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [CELL_W-1:0] snap_r [NCELLS];

    logic              accept_s;
    logic              in_range_s;
    logic [CELL_W-1:0] cur_code_s;
    logic              cur_empty_s;
    logic              last_s;
    logic [IDX_W-1:0]  next_ptr_s;

`ifdef EMPTY_SCAN_WRAP_EN
    // Number of cells already examined; the pointer alone cannot tell when
    // a wrapped scan has come back around to its starting cell.
    logic [IDX_W-1:0]  cnt_r;
`endif

    // Start is honoured in IDLE and in DONE (back-to-back scans), never in SCAN.
    always_comb begin
        accept_s = start && (fsm_r != ST_SCAN);
    end

    // Current-cell lookup, empty test and pointer-advance decision.
    always_comb begin
        in_range_s = ({1'b0, ptr_r} < NCELLS_EXT);
        cur_code_s = {CELL_W{1'b0}};
        if (in_range_s) begin
            cur_code_s = snap_r[ptr_r];
        end else begin
            cur_code_s = {CELL_W{1'b0}};
        end
        // An out-of-range start pointer examines nothing.
        cur_empty_s = in_range_s && is_empty(cur_code_s);
`ifdef EMPTY_SCAN_WRAP_EN
        last_s = (cnt_r == LAST_IDX);
        if (ptr_r == LAST_IDX) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = ptr_r + IDX_ONE;
        end
`else
        last_s     = (ptr_r == LAST_IDX);
        next_ptr_s = ptr_r + IDX_ONE;
`endif
    end

    // Snapshot of the cell array, captured when a scan is accepted.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < NCELLS; i++) begin
                snap_r[i] <= cells[i*CELL_W +: CELL_W];
            end
        end
    end

    // Control FSM, scan pointer and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r <= ST_IDLE;
            ptr_r <= {IDX_W{1'b0}};
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            idx   <= {IDX_W{1'b0}};
            state <= {CELL_W{1'b0}};
`ifdef EMPTY_SCAN_WRAP_EN
            cnt_r <= {IDX_W{1'b0}};
`endif
        end else begin
            case (fsm_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        fsm_r <= ST_SCAN;
                        ptr_r <= start_idx;
                        busy  <= 1'b1;
                        found <= 1'b0;
                        idx   <= {IDX_W{1'b0}};
                        state <= {CELL_W{1'b0}};
`ifdef EMPTY_SCAN_WRAP_EN
                        cnt_r <= {IDX_W{1'b0}};
`endif
                    end else begin
                        fsm_r <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (cur_empty_s) begin
                        fsm_r <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        found <= 1'b1;
                        idx   <= ptr_r;
                        state <= cur_code_s;
                    end else if (!in_range_s || last_s) begin
                        fsm_r <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        found <= 1'b0;
                    end else begin
                        ptr_r <= next_ptr_s;
`ifdef EMPTY_SCAN_WRAP_EN
                        cnt_r <= cnt_r + IDX_ONE;
`endif
                    end
                end
                default: begin
                    fsm_r <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_empty_cell_scanner.sv
module tb_empty_cell_scanner;

    localparam int N = 16;
    localparam int W = 4;
    localparam int IW = 4;

`ifdef EMPTY_SCAN_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  cells;
    logic            start;
    logic [IW-1:0]   start_idx;
    logic            busy, done, found;
    logic [IW-1:0]   idx;
    logic [W-1:0]    state;

    int vectors = 0;
    int miscompares = 0;

    empty_cell_scanner #(.NCELLS(N), .CELL_W(W)) dut (
        .clk(clk), .rst(rst), .cells(cells), .start(start),
        .start_idx(start_idx), .busy(busy), .done(done), .found(found),
        .idx(idx), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] c;
        int             s;
        int             f;
        int             ix;
        int             st;
        int             lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] fill(input logic [3:0] base,
                                            input int p1, input logic [3:0] v1,
                                            input int p2, input logic [3:0] v2);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = base;
        if (p1 >= 0) r[p1*W +: W] = v1;
        if (p2 >= 0) r[p2*W +: W] = v2;
        return r;
    endfunction

    // Reference: list the candidate cells in visiting order, return the first
    // empty one. lat = cycles from accepting edge T to the done cycle.
    task automatic model(input logic [N*W-1:0] c, input int s,
                         output int f, output int ix, output int st, output int lat);
        int n;
        int cand[$];
        f = 0; ix = 0; st = 0;
        if (s >= N) begin
            lat = 2;
            return;
        end
        n = WRAP ? N : N - s;
        for (int k = 0; k < n; k++) cand.push_back((s + k) % N);
        lat = n + 1;
        foreach (cand[k]) begin
            int code;
            code = int'(c[cand[k]*W +: W]);
            if (code == 0 || code == (1 << W) - 1) begin
                f = 1; ix = cand[k]; st = code; lat = k + 2;
                return;
            end
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (edge T),
    // returns #1 after edge T (i.e. in cycle T+1).
    task automatic launch(input logic [N*W-1:0] c, input int s);
        cells = c;
        start_idx = s[IW-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called in cycle T+1; waits for done and checks timing and result.
    task automatic wait_done(input string nm, input int f, input int ix,
                             input int st, input int lat);
        int cyc;
        int busy_bad;
        cyc = 1; busy_bad = 0;
        while (done !== 1'b1 && cyc <= 40) begin
            if (busy !== 1'b1) busy_bad = 1;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, lat);
        chk({nm, "_busy"}, busy_bad, 0);
        chk({nm, "_busy_in_done"}, int'(busy), 0);
        chk({nm, "_found"}, int'(found), f);
        chk({nm, "_idx"}, int'(idx), ix);
        chk({nm, "_state"}, int'(state), st);
    endtask

    initial begin
        int f, ix, st, lat, seen;
        logic [N*W-1:0] c;

        tbl[0] = '{fill(4'h5, 7, 4'h0, -1, 4'h0), 0, 1, 7, 0, 9};
        tbl[1] = '{fill(4'h2, 3, 4'hF, 10, 4'h0), 5, 1, 10, 0, 7};
        if (WRAP) tbl[2] = '{fill(4'h2, 3, 4'hF, 10, 4'h0), 11, 1, 3, 15, 10};
        else      tbl[2] = '{fill(4'h2, 3, 4'hF, 10, 4'h0), 11, 0, 0, 0, 6};
        tbl[3] = '{fill(4'h9, -1, 4'h0, -1, 4'h0), 0, 0, 0, 0, 17};
        tbl[4] = '{fill(4'h9, 15, 4'hF, -1, 4'h0), 15, 1, 15, 15, 2};
        if (WRAP) tbl[5] = '{fill(4'h3, 0, 4'h0, -1, 4'h0), 1, 1, 0, 0, 17};
        else      tbl[5] = '{fill(4'h3, 0, 4'h0, -1, 4'h0), 1, 0, 0, 0, 16};
        tbl[6] = '{fill(4'h1, 4, 4'hF, -1, 4'h0), 4, 1, 4, 15, 2};

        rst = 1'b1; start = 1'b0; start_idx = '0; cells = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_idx", int'(idx), 0);
        chk("reset_state", int'(state), 0);
        @(posedge clk); #1;

        // Directed table
        foreach (tbl[i]) begin
            launch(tbl[i].c, tbl[i].s);
            wait_done($sformatf("tbl%0d", i), tbl[i].f, tbl[i].ix, tbl[i].st, tbl[i].lat);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_hold_found", i), int'(found), tbl[i].f);
            chk($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
        end

        // Requests and cell changes during a scan are ignored
        launch(tbl[0].c, 0);
        @(posedge clk); #1;
        cells = fill(4'h5, 1, 4'h0, -1, 4'h0);
        start_idx = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int cyc;
            cyc = 3;
            while (done !== 1'b1 && cyc <= 40) begin
                @(posedge clk); #1; cyc++;
            end
            chk("ignore_latency", cyc, 9);
            chk("ignore_idx", int'(idx), 7);
            chk("ignore_found", int'(found), 1);
        end

        // Back-to-back: start issued in the DONE cycle
        launch(tbl[6].c, 4);
        wait_done("b2b_first", 1, 4, 15, 2);
        launch(tbl[1].c, 5);
        wait_done("b2b_second", 1, 10, 0, 7);

        // Reset mid-scan: busy drops next cycle, no done for the aborted scan
        @(posedge clk); #1;
        launch(tbl[3].c, 0);           // cycle T+1
        @(posedge clk); #1;            // T+2
        @(posedge clk); #1;            // T+3
        rst = 1'b1;
        @(posedge clk); #1;            // T+4
        rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_found", int'(found), 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_done", seen, 0);

        // Randomized scans against the reference model
        for (int r = 0; r < 40; r++) begin
            int s;
            for (int i = 0; i < N; i++) begin
                int sel;
                sel = $urandom_range(0, 11);
                if (sel == 0)      c[i*W +: W] = 4'h0;
                else if (sel == 1) c[i*W +: W] = 4'hF;
                else               c[i*W +: W] = 4'($urandom_range(1, 14));
            end
            s = $urandom_range(0, N - 1);
            model(c, s, f, ix, st, lat);
            launch(c, s);
            wait_done($sformatf("rand%0d", r), f, ix, st, lat);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
